multi_ch_tick_gen: RTL and testbench

//  Parametrised N-channel clock-enable generator driven by the 100 MHz board clock.

---
 rtl/multi_ch_tick_gen.sv | 107 ++++++++++
 tb/tb_multi_ch_tick_gen.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/multi_ch_tick_gen.sv
// N-channel clock-enable generator: runtime divisor per channel, one-cycle tick and 50% wave.
// Optional macro TICKGEN_SYNC_EN adds a sync_restart input that phase-aligns every channel.
module multi_ch_tick_gen #(
    parameter  int NUM_CH      = 4,
    parameter  int CNT_W       = 27,
    parameter  int DEFAULT_DIV = 2_000_000,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              resetSW_n,
`ifdef TICKGEN_SYNC_EN
    input  logic              sync_restart,
`endif
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    output logic [NUM_CH-1:0] cfg_pend,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] wave
);

    logic [CNT_W-1:0]  cnt_q    [NUM_CH];
    logic [CNT_W-1:0]  cnt_d    [NUM_CH];
    logic [CNT_W-1:0]  div_q    [NUM_CH];
    logic [CNT_W-1:0]  div_d    [NUM_CH];
    logic [CNT_W-1:0]  shadow_q [NUM_CH];
    logic [CNT_W-1:0]  shadow_d [NUM_CH];
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] tick_q, tick_d;
    logic [NUM_CH-1:0] wave_q, wave_d;
    logic              restart;

`ifdef TICKGEN_SYNC_EN
    assign restart = sync_restart;
`else
    assign restart = 1'b0;
`endif

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            // NOTE: every next-state signal is given its hold value first, so no path can infer a latch.
            cnt_d[i]    = cnt_q[i];
            div_d[i]    = div_q[i];
            shadow_d[i] = shadow_q[i];
            pend_d[i]   = pend_q[i];
            tick_d[i]   = tick_q[i];
            wave_d[i]   = wave_q[i];

            // div==0 is caught here, so div-1 below never underflows.
            if (restart || !ch_en[i] || div_q[i] == '0) begin
                cnt_d[i]  = '0;
                tick_d[i] = 1'b0;
                wave_d[i] = 1'b0;
                if (pend_q[i]) begin
                    div_d[i]  = shadow_q[i];
                    pend_d[i] = 1'b0;
                end
            end else if (cnt_q[i] == div_q[i] - CNT_W'(1)) begin
                cnt_d[i]  = '0;
                tick_d[i] = 1'b1;
                wave_d[i] = ~wave_q[i];
                if (pend_q[i]) begin
                    div_d[i]  = shadow_q[i];
                    pend_d[i] = 1'b0;
                end
            end else begin
                cnt_d[i]  = cnt_q[i] + CNT_W'(1);
                tick_d[i] = 1'b0;
            end

            // A write on an apply edge lands after the apply: old shadow used, new one stays pending.
            // Out-of-range indices match no channel and are dropped.
            if (cfg_we && int'(cfg_ch) == i) begin
                shadow_d[i] = cfg_div;
                pend_d[i]   = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetSW_n) begin
        if (!resetSW_n) begin
            // NOTE: these per-channel arrays are plain flops, not RAM, so every entry gets a reset value.
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]    <= '0;
                div_q[i]    <= CNT_W'(DEFAULT_DIV);
                shadow_q[i] <= CNT_W'(DEFAULT_DIV);
            end
            pend_q <= '0;
            tick_q <= '0;
            wave_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            tick_q   <= tick_d;
            wave_q   <= wave_d;
        end
    end

    assign cfg_pend = pend_q;
    assign tick     = tick_q;
    assign wave     = wave_q;

endmodule

// File: tb/tb_multi_ch_tick_gen.sv
// Scoreboard bench for multi_ch_tick_gen: a period-level reference model predicts tick/wave/pend.
module tb_multi_ch_tick_gen;
    localparam int NUM_CH = 5;
    localparam int CNT_W  = 27;
    localparam int DEF    = 20;
    localparam int CH_W   = 3;

    logic              clk = 1'b0;
    logic              resetSW_n;
    logic              sync_restart;
    logic [NUM_CH-1:0] ch_en;
    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic [NUM_CH-1:0] cfg_pend, tick, wave;

    always #5 clk = ~clk;

    multi_ch_tick_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_DIV(DEF)) dut (
        .clk(clk),
        .resetSW_n(resetSW_n),
`ifdef TICKGEN_SYNC_EN
        .sync_restart(sync_restart),
`endif
        .ch_en(ch_en),
        .cfg_we(cfg_we),
        .cfg_ch(cfg_ch),
        .cfg_div(cfg_div),
        .cfg_pend(cfg_pend),
        .tick(tick),
        .wave(wave)
    );

    typedef struct packed {
        logic [NUM_CH-1:0] tick;
        logic [NUM_CH-1:0] wave;
        logic [NUM_CH-1:0] pend;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: period length, pending value, position inside the current period,
    // and number of completed periods since the channel last started (wave = its parity).
    int m_div[NUM_CH], m_shadow[NUM_CH], m_pos[NUM_CH], m_periods[NUM_CH];
    bit m_pend[NUM_CH], m_tick[NUM_CH];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_div[i] = DEF; m_shadow[i] = DEF; m_pos[i] = 0;
            m_periods[i] = 0; m_pend[i] = 0; m_tick[i] = 0;
        end
    endfunction

    function automatic void model_step();
        bit stopped, ends;
        for (int i = 0; i < NUM_CH; i++) begin
            stopped = (sync_restart === 1'b1) || !ch_en[i] || m_div[i] == 0;
            ends    = !stopped && (m_pos[i] + 1 == m_div[i]);
            m_tick[i] = ends;
            if (stopped) begin
                m_pos[i] = 0; m_periods[i] = 0;
            end else if (ends) begin
                m_pos[i] = 0; m_periods[i] = m_periods[i] + 1;
            end else begin
                m_pos[i] = m_pos[i] + 1;
            end
            if ((stopped || ends) && m_pend[i]) begin
                m_div[i] = m_shadow[i]; m_pend[i] = 0;
            end
            if (cfg_we && int'(cfg_ch) == i) begin
                m_shadow[i] = int'(cfg_div); m_pend[i] = 1;
            end
        end
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        for (int i = 0; i < NUM_CH; i++) begin
            e.tick[i] = m_tick[i];
            e.wave[i] = (m_periods[i] % 2) == 1;
            e.pend[i] = m_pend[i];
        end
        return e;
    endfunction

    // One clock: inputs are already driven; the model advances on the same edge.
    task automatic step();
        @(posedge clk);
        model_step();
        exp_q.push_back(model_out());
        #1;
        cfg_we = 1'b0;
        sync_restart = 1'b0;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic cfg_write(input int ch, input int dv);
        cfg_we = 1'b1; cfg_ch = CH_W'(ch); cfg_div = CNT_W'(dv);
        step();
    endtask

    // Monitor: compare the oldest prediction against the DUT between edges.
    exp_t mon_e;
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("tick", 64'(tick), 64'(mon_e.tick));
                check("wave", 64'(wave), 64'(mon_e.wave));
                check("pend", 64'(cfg_pend), 64'(mon_e.pend));
            end
        end
    end

    int edge_n, k;

    initial begin
        resetSW_n = 1'b0; ch_en = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0; sync_restart = 1'b0;
        model_reset();
        #12;
        check("reset_tick", 64'(tick), 64'd0);
        check("reset_wave", 64'(wave), 64'd0);
        check("reset_pend", 64'(cfg_pend), 64'd0);
        resetSW_n = 1'b1;

        // Default divisor on ch0 only: first tick after edge DEF.
        ch_en = 5'b00001;
        edge_n = 0;
        for (k = 0; k < 3 * DEF && tick[0] !== 1'b1; k++) begin
            step(); edge_n++;
        end
        check("first_default_tick_edge", 64'(edge_n), 64'(DEF));
        run(DEF + 5);

        // All channels to div=4 while idle, then enable together: ticks after edges 4, 8, 12.
        ch_en = '0;
        for (int c = 0; c < NUM_CH; c++) cfg_write(c, 4);
        step();
        ch_en = '1;
        for (int e = 1; e <= 12; e++) begin
            step();
            check("div4_tick_phase", 64'(tick), (e % 4 == 0) ? 64'(5'b11111) : 64'd0);
        end
        run(10);

        // Retarget ch0 to 10, then write 3 at position 4 of a 10-period.
        cfg_write(0, 10);
        for (k = 0; k < 100 && !(m_div[0] == 10 && m_pos[0] == 4); k++) step();
        check("reach_div10_pos4", 64'(k < 100), 64'd1);
        cfg_write(0, 3);
        run(25);

        // Pending 7, then write 5 exactly on the boundary edge: one 7-period, then 5s.
        for (k = 0; k < 100 && !(m_div[0] == 3 && !m_pend[0] && m_pos[0] == 0); k++) step();
        cfg_write(0, 7);
        for (k = 0; k < 100 && m_pos[0] + 1 != m_div[0]; k++) step();
        check("reach_boundary_pend7", 64'(m_pend[0] && k < 100), 64'd1);
        cfg_write(0, 5);
        run(30);

        // Out-of-range writes are ignored; div=0 parks channel 2.
        cfg_write(5, 9);
        cfg_write(7, 2);
        run(5);
        cfg_write(2, 0);
        run(20);
        check("parked_tick", 64'(tick[2]), 64'd0);
        check("parked_wave", 64'(wave[2]), 64'd0);

        // Randomised traffic with small divisors so boundaries and applies collide often.
        for (int n = 0; n < 1500; n++) begin
            for (int c = 0; c < NUM_CH; c++) ch_en[c] = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 9) == 0) begin
                cfg_we = 1'b1;
                cfg_ch = CH_W'($urandom_range(0, 7));
                cfg_div = CNT_W'($urandom_range(0, 9));
            end
`ifdef TICKGEN_SYNC_EN
            sync_restart = ($urandom_range(0, 49) == 0);
`endif
            step();
        end

`ifdef TICKGEN_SYNC_EN
        // Equal divisors, then one restart pulse: every channel ticks in phase.
        ch_en = '1;
        for (int c = 0; c < NUM_CH; c++) cfg_write(c, 6);
        run(15);
        sync_restart = 1'b1;
        step();
        for (int e = 1; e <= 12; e++) begin
            step();
            check("sync_in_phase", 64'(tick), (e % 6 == 0) ? 64'(5'b11111) : 64'd0);
        end
`endif

        // Async reset between edges with a long pending write outstanding.
        ch_en = '1;
        cfg_write(0, 9);
        for (k = 0; k < 100 && m_pend[0]; k++) step();
        cfg_write(0, 8);
        run(5);
        #2;
        resetSW_n = 1'b0;
        #1;
        check("async_tick", 64'(tick), 64'd0);
        check("async_wave", 64'(wave), 64'd0);
        check("async_pend", 64'(cfg_pend), 64'd0);
        model_reset();
        exp_q.delete();
        #4;
        resetSW_n = 1'b1;
        ch_en = 5'b00011;
        run(2 * DEF + 5);

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
